// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between the in-order
//   writeback stage (strict priority) and the MUL/DIV completion stream.
//   MUL/DIV results wait in a small FIFO while the pipeline owns the port.
//   A busy scoreboard tracks MUL/DIV destinations in flight, and the block
//   raises a decode stall on RAW/WAW hazards against them.
module regfile_wb_arbiter #(
   parameter int MD_FIFO_DEPTH = 2,
   parameter int CNT_W         = $clog2(MD_FIFO_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   // pipeline writeback, never back-pressured
   input  logic             wb_valid,
   input  logic [4:0]       wb_rd,
   input  logic [31:0]      wb_data,
   // MUL/DIV completion stream
   input  logic             md_valid,
   input  logic [4:0]       md_rd,
   input  logic [31:0]      md_data,
   output logic             md_ready,
   // MUL/DIV issue, feeds the scoreboard
   input  logic             md_issue,
   input  logic [4:0]       md_issue_rd,
   // decode-stage operands
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   output logic             hazard_stall,
   // register file write port
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [31:0]      rf_wdata,
   output logic [CNT_W-1:0] fifo_count
);

   // Depth is a power of two, so the pointers wrap naturally.
   localparam int PTR_W = (MD_FIFO_DEPTH > 1) ? $clog2(MD_FIFO_DEPTH) : 1;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } md_entry_t;

   md_entry_t        fifo_mem [MD_FIFO_DEPTH];
   md_entry_t        head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;
   logic [31:0]      busy;
   logic [31:0]      busy_set;
   logic [31:0]      busy_clr;

   // Readiness uses the pre-edge count: a pop in the same cycle does not
   // open a slot early, which keeps md_ready free of any wb_valid path.
   assign md_ready   = !rst && (count != CNT_W'(MD_FIFO_DEPTH));
   assign push       = md_valid && md_ready;
   // The pipeline always wins; the FIFO drains only on idle WB cycles.
   assign pop        = !wb_valid && (count != '0);
   assign head       = fifo_mem[rd_ptr];
   assign fifo_count = count;

   // FIFO storage holds data only, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= {md_rd, md_data};
   end

   // FIFO pointers and occupancy. Push+pop leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Scoreboard update masks: issue sets, drain clears.
   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      if (md_issue && (md_issue_rd != 5'd0))
         busy_set[md_issue_rd] = 1'b1;
      if (pop)
         busy_clr[head.rd] = 1'b1;
   end

   // Busy scoreboard. Set is applied after clear so it wins on the same
   // index, and x0 is never busy. Pipeline writes leave it alone.
   always_ff @(posedge clk) begin
      if (rst)
         busy <= '0;
      else
         busy <= ((busy & ~busy_clr) | busy_set) & ~32'h1;
   end

   // Decode stall. It drops on the cycle the drained result sits on the
   // write port; the register file's read-during-write bypass covers it.
   always_comb begin
      hazard_stall = ((id_rs1 != 5'd0) && busy[id_rs1]) ||
                     ((id_rs2 != 5'd0) && busy[id_rs2]) ||
                     ((id_rd  != 5'd0) && busy[id_rd]);
   end

   // Registered write port. Writes to x0 still consume the slot but do not
   // assert the enable. Address and data hold on idle cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else if (wb_valid) begin
         rf_we    <= (wb_rd != 5'd0);
         rf_waddr <= wb_rd;
         rf_wdata <= wb_data;
      end else if (pop) begin
         rf_we    <= (head.rd != 5'd0);
         rf_waddr <= head.rd;
         rf_wdata <= head.data;
      end else begin
         rf_we    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

   localparam int DEPTH = 2;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk;
   logic             rst;
   logic             wb_valid;
   logic [4:0]       wb_rd;
   logic [31:0]      wb_data;
   logic             md_valid;
   logic [4:0]       md_rd;
   logic [31:0]      md_data;
   logic             md_ready;
   logic             md_issue;
   logic [4:0]       md_issue_rd;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic [4:0]       id_rd;
   logic             hazard_stall;
   logic             rf_we;
   logic [4:0]       rf_waddr;
   logic [31:0]      rf_wdata;
   logic [CNT_W-1:0] fifo_count;

   int n_chk  = 0;
   int n_fail = 0;

   regfile_wb_arbiter #(.MD_FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
      .md_issue(md_issue), .md_issue_rd(md_issue_rd),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .hazard_stall(hazard_stall),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fifo_count(fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wbv;
      logic [4:0]  wbrd;
      logic [31:0] wbd;
      logic        mdv;
      logic [4:0]  mdrd;
      logic [31:0] mdd;
      logic        iss;
      logic [4:0]  issrd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rdd;
   } in_t;

   typedef struct {
      in_t         i;
      logic        e_ready;
      logic        e_stall;
      logic        e_we;
      logic [4:0]  e_waddr;
      logic [31:0] e_wdata;
      int          e_cnt;
   } vec_t;

   vec_t vq[$];

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   function automatic in_t mk(input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                              input logic mdv, input logic [4:0] mdrd, input logic [31:0] mdd,
                              input logic iss, input logic [4:0] issrd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rdd);
      in_t r;
      r.wbv = wbv; r.wbrd = wbrd; r.wbd = wbd;
      r.mdv = mdv; r.mdrd = mdrd; r.mdd = mdd;
      r.iss = iss; r.issrd = issrd;
      r.rs1 = rs1; r.rs2 = rs2; r.rdd = rdd;
      return r;
   endfunction

   task automatic add(input in_t i, input logic r, input logic s, input logic w,
                      input logic [4:0] a, input logic [31:0] d, input int c);
      vec_t v;
      v.i = i; v.e_ready = r; v.e_stall = s; v.e_we = w;
      v.e_waddr = a; v.e_wdata = d; v.e_cnt = c;
      vq.push_back(v);
   endtask

   task automatic apply(input in_t i);
      wb_valid = i.wbv; wb_rd = i.wbrd; wb_data = i.wbd;
      md_valid = i.mdv; md_rd = i.mdrd; md_data = i.mdd;
      md_issue = i.iss; md_issue_rd = i.issrd;
      id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rdd;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   in_t  idle;
   ent_t mq[$];
   bit   mbusy[32];
   logic m_we;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;

   initial begin
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // ---------------- directed table ----------------
      // ready/stall checked before the edge, rf_* and count after it
      add(mk(0,0,0,            0,0,0,             0,0, 5,5,5), 1,0, 0,0,0,                   0); // 0 idle
      add(mk(1,3,32'hDEADBEEF, 0,0,0,             0,0, 0,0,0), 1,0, 1,3,32'hDEADBEEF,        0); // 1 wb write
      add(idle,                                               1,0, 0,3,32'hDEADBEEF,        0); // 2 hold
      add(mk(0,0,0,            0,0,0,             1,7, 7,0,0), 1,0, 0,3,32'hDEADBEEF,        0); // 3 issue x7
      add(mk(0,0,0,            0,0,0,             0,0, 7,0,0), 1,1, 0,3,32'hDEADBEEF,        0); // 4 RAW stall
      add(mk(0,0,0,            1,7,32'h12345678,  0,0, 7,0,0), 1,1, 0,3,32'hDEADBEEF,        1); // 5 accept
      add(mk(0,0,0,            0,0,0,             0,0, 7,0,0), 1,1, 1,7,32'h12345678,        0); // 6 drain
      add(mk(0,0,0,            0,0,0,             0,0, 7,0,0), 1,0, 0,7,32'h12345678,        0); // 7 stall dropped
      add(mk(1,1,32'h11,       1,10,32'hA0,       0,0, 0,0,0), 1,0, 1,1,32'h11,              1); // 8 starve
      add(mk(1,2,32'h22,       1,11,32'hA1,       0,0, 0,0,0), 1,0, 1,2,32'h22,              2); // 9
      add(mk(1,3,32'h33,       1,12,32'hA2,       0,0, 0,0,0), 0,0, 1,3,32'h33,              2); // 10 full
      add(mk(1,4,32'h44,       1,12,32'hA2,       0,0, 0,0,0), 0,0, 1,4,32'h44,              2); // 11
      add(mk(0,0,0,            1,12,32'hA2,       0,0, 0,0,0), 0,0, 1,10,32'hA0,             1); // 12 pop, no early slot
      add(mk(0,0,0,            1,12,32'hA2,       0,0, 0,0,0), 1,0, 1,11,32'hA1,             1); // 13 push+pop
      add(idle,                                               1,0, 1,12,32'hA2,             0); // 14
      add(idle,                                               1,0, 0,12,32'hA2,             0); // 15
      add(mk(1,0,32'h55,       1,0,32'h66,        0,0, 0,0,0), 1,0, 0,0,32'h55,              1); // 16 x0 writes
      add(idle,                                               1,0, 0,0,32'h66,              0); // 17 x0 pop
      add(mk(0,0,0,            0,0,0,             1,0, 0,0,0), 1,0, 0,0,32'h66,              0); // 18 issue x0
      add(idle,                                               1,0, 0,0,32'h66,              0); // 19
      add(mk(0,0,0,            0,0,0,             1,6, 0,0,0), 1,0, 0,0,32'h66,              0); // 20 issue x6
      add(mk(0,0,0,            0,0,0,             0,0, 0,6,0), 1,1, 0,0,32'h66,              0); // 21 rs2 hazard
      add(mk(0,0,0,            0,0,0,             0,0, 0,0,6), 1,1, 0,0,32'h66,              0); // 22 WAW hazard
      add(mk(1,6,32'h77,       0,0,0,             0,0, 0,0,6), 1,1, 1,6,32'h77,              0); // 23 wb keeps busy
      add(mk(0,0,0,            0,0,0,             0,0, 0,0,6), 1,1, 0,6,32'h77,              0); // 24

      // ---------------- reset ----------------
      rst = 1'b1;
      apply(idle);
      #2;
      chk("rst_md_ready", {31'd0, md_ready}, 32'd0);
      step(); step();
      rst = 1'b0;
      #1;
      chk("rst_rf_we",    {31'd0, rf_we}, 32'd0);
      chk("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_count",    32'(fifo_count), 32'd0);

      foreach (vq[k]) begin
         apply(vq[k].i);
         #1;
         chk($sformatf("v%0d_md_ready", k), {31'd0, md_ready}, {31'd0, vq[k].e_ready});
         chk($sformatf("v%0d_stall", k), {31'd0, hazard_stall}, {31'd0, vq[k].e_stall});
         step();
         chk($sformatf("v%0d_rf_we", k), {31'd0, rf_we}, {31'd0, vq[k].e_we});
         chk($sformatf("v%0d_rf_waddr", k), {27'd0, rf_waddr}, {27'd0, vq[k].e_waddr});
         chk($sformatf("v%0d_rf_wdata", k), rf_wdata, vq[k].e_wdata);
         chk($sformatf("v%0d_count", k), 32'(fifo_count), 32'(vq[k].e_cnt));
      end

      // ---------------- reset mid-operation ----------------
      apply(mk(0,0,0, 0,0,0, 1,9, 0,0,0));
      step();
      apply(mk(1,1,32'h100, 1,20,32'hAAAA0001, 0,0, 9,0,0));
      step();
      apply(mk(1,2,32'h200, 1,21,32'hAAAA0002, 0,0, 9,0,0));
      step();
      chk("mid_count_full", 32'(fifo_count), 32'd2);
      chk("mid_stall_x9", {31'd0, hazard_stall}, 32'd1);
      apply(mk(0,0,0, 0,0,0, 0,0, 9,0,0));
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", {31'd0, md_ready}, 32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("mid_count", 32'(fifo_count), 32'd0);
      chk("mid_rf_we", {31'd0, rf_we}, 32'd0);
      chk("mid_rf_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("mid_stall", {31'd0, hazard_stall}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("post_rst%0d_rf_we", k), {31'd0, rf_we}, 32'd0);
         chk($sformatf("post_rst%0d_count", k), 32'(fifo_count), 32'd0);
      end

      // ---------------- randomized against a queue model ----------------
      rst = 1'b1;
      apply(idle);
      step();
      rst = 1'b0;
      mq.delete();
      foreach (mbusy[k]) mbusy[k] = 1'b0;
      m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      begin
         logic        pend;
         logic        r_rst;
         logic        e_ready;
         logic        e_stall;
         logic        do_push;
         logic        do_pop;
         logic [4:0]  irs1, irs2, irdd, irs;
         in_t         cur;
         ent_t        h;
         ent_t        ne;
         pend = 1'b0;
         cur  = idle;
         for (int c = 0; c < 800; c++) begin
            r_rst = ($urandom_range(0, 79) == 0);
            cur.wbv  = ($urandom_range(0, 9) < 4);
            cur.wbrd = 5'($urandom_range(0, 7));
            cur.wbd  = $urandom;
            if (!pend) begin
               cur.mdv  = ($urandom_range(0, 1) == 1);
               cur.mdrd = 5'($urandom_range(0, 7));
               cur.mdd  = $urandom;
            end
            irs1 = 5'($urandom_range(0, 7));
            irs2 = 5'($urandom_range(0, 7));
            irdd = 5'($urandom_range(0, 7));
            irs  = 5'($urandom_range(0, 7));
            cur.rs1 = irs1; cur.rs2 = irs2; cur.rdd = irdd;
            e_stall = (irs1 != 0 && mbusy[irs1]) || (irs2 != 0 && mbusy[irs2]) ||
                      (irdd != 0 && mbusy[irdd]);
            cur.issrd = irs;
            cur.iss   = ($urandom_range(0, 2) == 0) && !e_stall && !mbusy[irs];
            e_ready   = !r_rst && (mq.size() != DEPTH);
            rst = r_rst;
            apply(cur);
            #1;
            chk($sformatf("r%0d_md_ready", c), {31'd0, md_ready}, {31'd0, e_ready});
            chk($sformatf("r%0d_stall", c), {31'd0, hazard_stall}, {31'd0, e_stall});
            if (r_rst) begin
               mq.delete();
               foreach (mbusy[k]) mbusy[k] = 1'b0;
               m_we = 1'b0; m_waddr = '0; m_wdata = '0;
               pend = 1'b0;
            end else begin
               do_push = cur.mdv && e_ready;
               do_pop  = !cur.wbv && (mq.size() > 0);
               if (cur.wbv) begin
                  m_we = (cur.wbrd != 0); m_waddr = cur.wbrd; m_wdata = cur.wbd;
               end else if (do_pop) begin
                  h = mq.pop_front();
                  m_we = (h.rd != 0); m_waddr = h.rd; m_wdata = h.data;
                  mbusy[h.rd] = 1'b0;
               end else begin
                  m_we = 1'b0;
               end
               if (cur.iss && cur.issrd != 0) mbusy[cur.issrd] = 1'b1;
               if (do_push) begin
                  ne.rd = cur.mdrd; ne.data = cur.mdd;
                  mq.push_back(ne);
               end
               pend = cur.mdv && !do_push;
            end
            step();
            chk($sformatf("r%0d_rf_we", c), {31'd0, rf_we}, {31'd0, m_we});
            chk($sformatf("r%0d_rf_waddr", c), {27'd0, rf_waddr}, {27'd0, m_waddr});
            chk($sformatf("r%0d_rf_wdata", c), rf_wdata, m_wdata);
            chk($sformatf("r%0d_count", c), 32'(fifo_count), 32'(mq.size()));
         end
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Arbitrates the register file's single write port between the in-order pipeline writeback stage and the multi-cycle MUL/DIV completion stream.
- MUL/DIV results are buffered in a small FIFO while the pipeline holds the port.
- Keeps a busy scoreboard of destinations with MUL/DIV ops in flight and raises a decode-stage stall on RAW/WAW hazards.
- Sits between the WB stage / MUL-DIV unit and the register file write port (write enable, write address, write data).

Parameters:
- MD_FIFO_DEPTH, 2, MUL/DIV result buffer entries (power of two, >=2)
- CNT_W, $clog2(MD_FIFO_DEPTH+1), width of fifo_count

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- wb_valid  in  1  pipeline writeback valid; always accepted, never back-pressured
- wb_rd  in  5  pipeline writeback destination
- wb_data  in  32  pipeline writeback data
- md_valid  in  1  MUL/DIV result valid
- md_rd  in  5  MUL/DIV result destination
- md_data  in  32  MUL/DIV result data
- md_ready  out  1  FIFO can accept a MUL/DIV result
- md_issue  in  1  MUL/DIV op issued this cycle
- md_issue_rd  in  5  destination of the issued MUL/DIV op
- id_rs1  in  5  decode-stage source 1
- id_rs2  in  5  decode-stage source 2
- id_rd  in  5  decode-stage destination
- hazard_stall  out  1  decode must stall
- rf_we  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  32  register file write data
- fifo_count  out  CNT_W  buffered MUL/DIV results

Behaviour:
Reset (rst high at posedge):
- FIFO emptied; busy[31:0] cleared; rf_we=0, rf_waddr=0, rf_wdata=0, fifo_count=0.
- md_ready is 0 while rst is high.
- Reset mid-operation discards buffered results and all busy bits.

MUL/DIV accept:
- md_ready = !rst && (fifo_count != MD_FIFO_DEPTH).
- md_ready is computed from the pre-edge count; a same-cycle pop does not free a slot early.
- Push on posedge when md_valid && md_ready.
- md_data/md_rd are sampled only on accept and must hold while md_valid && !md_ready.

Write-port arbitration (evaluated each cycle; rf_* registered, loaded at posedge):
- wb_valid=1: wb wins. rf_we <= (wb_rd!=0), rf_waddr <= wb_rd, rf_wdata <= wb_data. FIFO does not pop.
- Else if FIFO non-empty: pop head. rf_we <= (head.rd!=0), rf_waddr <= head.rd, rf_wdata <= head.data. busy[head.rd] cleared at the same edge.
- Else: rf_we <= 0; rf_waddr and rf_wdata hold.
- WB-to-port latency is 1 cycle. MUL/DIV minimum latency is 2 cycles (accept edge, then drain edge).
- The FIFO has no bypass.
- Simultaneous push and pop: fifo_count unchanged; FIFO order preserved.
- Pointers wrap modulo MD_FIFO_DEPTH.
- The pipeline has strict priority over MUL/DIV. Sustained wb_valid starves the FIFO, and md_ready backpressure absorbs it.

Scoreboard:
- md_issue && md_issue_rd!=0 sets busy[md_issue_rd] at posedge.
- Set and clear of the same index at the same edge: set wins.
- busy[0] is always 0.
- A pipeline write does not clear busy bits.

Hazard stall:
- hazard_stall (combinational) = busy[id_rs1] | busy[id_rs2] | busy[id_rd], each term gated by address != 0.
- The clear happens at the drain edge, so the cycle rf_we presents the result is also the first cycle hazard_stall drops. The register file's read-during-write bypass supplies the data in that cycle.
- Upstream guarantees md_issue only with hazard_stall low, so no double-issue to a busy rd.

Test Plan:
- Reset, then idle -> rf_we=0, rf_waddr=0, rf_wdata=0, md_ready=1, fifo_count=0, hazard_stall=0 for id_rs1=id_rs2=id_rd=5.
- wb_valid=1, wb_rd=3, wb_data=0xDEADBEEF for one cycle -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF; then rf_we=0.
- md_issue_rd=7; id_rs1=7 -> hazard_stall=1. md_valid, md_rd=7, md_data=0x12345678 with wb idle -> rf_we=1, rf_waddr=7 two cycles after accept; hazard_stall=0 in that same cycle.
- wb_valid held 4 cycles while 3 MUL/DIV results are offered, depth 2 -> fifo_count reaches 2 and md_ready=0. The third result waits. After wb_valid drops, the writes arrive in FIFO order on consecutive cycles.
- wb_rd=0 and md_rd=0 results -> rf_we stays 0. A md_rd=0 result still pops (fifo_count decrements). md_issue_rd=0 never raises hazard_stall.
- rst asserted with 2 entries buffered and busy[9] set -> fifo_count=0, hazard_stall=0 for id_rs1=9, rf_we=0; no stale write after rst deasserts.
